// File: rtl/multiword_addsub_seq.sv
// Wide add/subtract sequenced through one 16-bit carry-select slice,
// one word per clock, least significant word first.
module multiword_addsub_seq #(
    parameter int NWORDS = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start_valid,
    output logic                   start_ready,
    input  logic                   sub,
    input  logic [16*NWORDS-1:0]   a,
    input  logic [16*NWORDS-1:0]   b,
    output logic                   res_valid,
    input  logic                   res_ready,
    output logic [16*NWORDS-1:0]   sum,
    output logic                   cout,
    output logic                   ovf,
    output logic                   busy
);

    localparam int IW = $clog2(NWORDS);
    localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t                   state;
    logic [IW-1:0]            idx;
    logic                     carry;
    logic                     sub_q;
    logic [NWORDS-1:0][15:0]  a_q;
    logic [NWORDS-1:0][15:0]  b_q;
    logic [NWORDS-1:0][15:0]  sum_q;

    logic [15:0] aw;
    logic [15:0] bw;
    logic [15:0] rw;
    logic        cw;
    logic [8:0]  lo;
    logic [8:0]  hi0;
    logic [8:0]  hi1;
    logic [8:0]  hsel;

    // Carry-select slice: low byte ripples, high byte is precomputed
    // for both carry-in values and picked by the low-byte carry.
    always_comb begin
        aw   = a_q[idx];
        bw   = b_q[idx] ^ {16{sub_q}};
        lo   = {1'b0, aw[7:0]} + {1'b0, bw[7:0]} + {8'd0, carry};
        hi0  = {1'b0, aw[15:8]} + {1'b0, bw[15:8]};
        hi1  = {1'b0, aw[15:8]} + {1'b0, bw[15:8]} + 9'd1;
        hsel = lo[8] ? hi1 : hi0;
        rw   = {hsel[7:0], lo[7:0]};
        cw   = hsel[8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            idx   <= '0;
            carry <= 1'b0;
            sub_q <= 1'b0;
            a_q   <= '0;
            b_q   <= '0;
            sum_q <= '0;
            cout  <= 1'b0;
            ovf   <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start_valid) begin
                        a_q   <= a;
                        b_q   <= b;
                        sub_q <= sub;
                        idx   <= '0;
                        carry <= sub;
                        state <= RUN;
                    end
                end
                RUN: begin
                    sum_q[idx] <= rw;
                    carry      <= cw;
                    if (idx == LAST) begin
                        cout  <= cw;
                        ovf   <= (aw[15] == bw[15]) && (rw[15] != aw[15]);
                        state <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    if (res_ready) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign sum         = sum_q;
    assign start_ready = (state == IDLE);
    assign res_valid   = (state == DONE);
    assign busy        = (state != IDLE);

endmodule

// File: tb/tb_multiword_addsub_seq.sv
// Scoreboard bench for multiword_addsub_seq: driver pushes model results,
// a negedge monitor pops and compares them while res_valid is high.
module tb_multiword_addsub_seq;

    localparam int NWORDS = 4;
    localparam int W = 16 * NWORDS;

    logic         clk = 1'b0;
    logic         rst;
    logic         start_valid;
    logic         start_ready;
    logic         sub;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;
    logic         busy;

    multiword_addsub_seq #(.NWORDS(NWORDS)) dut (
        .clk(clk),
        .rst(rst),
        .start_valid(start_valid),
        .start_ready(start_ready),
        .sub(sub),
        .a(a),
        .b(b),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .sum(sum),
        .cout(cout),
        .ovf(ovf),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] sum;
        logic         cout;
        logic         ovf;
        int           acc;
    } exp_t;

    exp_t sb[$];
    exp_t cur;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   n_sent = 0;
    int   n_res = 0;
    bit   prev_v = 1'b0;
    bit   have = 1'b0;

    always @(posedge clk) cyc++;

    task automatic chk(input string nm, input logic [W-1:0] act,
                       input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    // Full-width arithmetic reference
    function automatic exp_t model(bit s, logic [W-1:0] x, logic [W-1:0] y);
        exp_t r;
        logic [W:0] full;
        if (!s) begin
            full   = {1'b0, x} + {1'b0, y};
            r.sum  = full[W-1:0];
            r.cout = full[W];
            r.ovf  = (x[W-1] == y[W-1]) && (r.sum[W-1] != x[W-1]);
        end else begin
            r.sum  = x - y;
            r.cout = (x >= y);
            r.ovf  = (x[W-1] != y[W-1]) && (r.sum[W-1] != x[W-1]);
        end
        r.acc = 0;
        return r;
    endfunction

    function automatic logic [W-1:0] pick();
        case ($urandom_range(0, 5))
            0: return '0;
            1: return '1;
            2: return {1'b1, {(W-1){1'b0}}};
            3: return {1'b0, {(W-1){1'b1}}};
            4: return W'($urandom_range(0, 3));
            default: return {$urandom, $urandom};
        endcase
    endfunction

    always @(negedge clk) begin
        if (rst) begin
            prev_v = 1'b0;
            have   = 1'b0;
        end else begin
            if (res_valid && !prev_v) begin
                if (sb.size() == 0) begin
                    chk("unexpected_result", 1, 0);
                    have = 1'b0;
                end else begin
                    cur  = sb.pop_front();
                    have = 1'b1;
                    n_res++;
                    chk("latency", W'(cyc - cur.acc), W'(NWORDS));
                end
            end
            if (res_valid && have) begin
                chk("sum", sum, cur.sum);
                chk("cout", W'(cout), W'(cur.cout));
                chk("ovf", W'(ovf), W'(cur.ovf));
                chk("ready_in_done", W'(start_ready), 0);
                chk("busy_in_done", W'(busy), 1);
            end
            prev_v = res_valid;
        end
    end

    task automatic wait_idle();
        int n = 0;
        @(negedge clk);
        while (!start_ready && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (!start_ready) chk("idle_timeout", 0, 1);
    endtask

    task automatic send(input bit s, input logic [W-1:0] x,
                        input logic [W-1:0] y);
        exp_t e;
        wait_idle();
        start_valid = 1'b1;
        sub = s;
        a = x;
        b = y;
        e = model(s, x, y);
        e.acc = cyc + 1;
        sb.push_back(e);
        n_sent++;
        @(negedge clk);
        start_valid = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        sub = 1'($urandom);
        chk("accepted", W'(busy), 1);
    endtask

    initial begin
        int n;
        int t0;
        exp_t e;
        rst = 1'b1;
        start_valid = 1'b0;
        sub = 1'b0;
        a = '0;
        b = '0;
        res_ready = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        chk("rst_start_ready", W'(start_ready), 1);
        chk("rst_res_valid", W'(res_valid), 0);
        chk("rst_busy", W'(busy), 0);
        chk("rst_sum", sum, 0);
        chk("rst_cout", W'(cout), 0);
        chk("rst_ovf", W'(ovf), 0);

        send(0, '1, 64'h1);
        send(1, 64'h0000_0000_0001_0000, 64'h1);
        send(1, 64'h0, 64'h1);
        send(0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1);
        send(1, 64'h8000_0000_0000_0000, 64'h1);

        // Backpressure with noise on the command port
        wait_idle();
        res_ready = 1'b0;
        send(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom});
        n = 0;
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!res_valid) chk("bp_timeout", 0, 1);
        repeat (5) begin
            @(negedge clk);
            start_valid = 1'($urandom);
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            sub = 1'($urandom);
        end
        @(negedge clk);
        start_valid = 1'b0;
        res_ready = 1'b1;
        @(negedge clk);
        chk("bp_release_ready", W'(start_ready), 1);
        chk("bp_release_valid", W'(res_valid), 0);

        // Asynchronous reset in the second RUN cycle
        send(0, {$urandom, $urandom}, {$urandom, $urandom});
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("arst_res_valid", W'(res_valid), 0);
        chk("arst_sum", sum, 0);
        chk("arst_busy", W'(busy), 0);
        chk("arst_ready", W'(start_ready), 1);
        chk("arst_cout_ovf", W'({cout, ovf}), 0);
        void'(sb.pop_back());
        n_sent--;
        start_valid = 1'b1;
        a = {$urandom, $urandom};
        @(negedge clk);
        @(negedge clk);
        start_valid = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        chk("start_in_reset_ignored", W'(busy), 0);
        send(0, 64'h1234, 64'h1111);
        chk("post_rst_model", sb[sb.size()-1].sum, 64'h2345);

        // Back-to-back with start_valid and res_ready held high
        wait_idle();
        start_valid = 1'b1;
        sub = 1'b0;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        e = model(sub, a, b);
        t0 = cyc + 1;
        e.acc = t0;
        sb.push_back(e);
        @(negedge clk);
        sub = 1'b1;
        a = {$urandom, $urandom};
        b = {$urandom, $urandom};
        e = model(sub, a, b);
        e.acc = t0 + NWORDS + 2;
        sb.push_back(e);
        n_sent += 2;
        n = 0;
        while (!start_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!start_ready) chk("b2b_timeout", 0, 1);
        @(negedge clk);
        start_valid = 1'b0;
        chk("b2b_second_accept", W'(busy), 1);

        for (int i = 0; i < 24; i++) begin
            send(1'($urandom), pick(), pick());
        end

        wait_idle();
        chk("sb_drained", W'(sb.size()), 0);
        chk("result_count", W'(n_res), W'(n_sent));
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
